telemetry_framer: RTL and testbench

Parametrised multi-channel telemetry framer. It snapshots up to eight sensor channels (ultrasonic distance, direction, pitch, IR code, …) on a periodic tick or on demand. It serialises them into a byte frame with sync, sequence, channel mask and checksum. The frame is handed byte-by-byte to `uart_tx` over a valid/ready handshake, and the block sits between the sensor pipelines and the UART link to the base station.

---
 rtl/telemetry_pkg.sv | 18 +
 rtl/tick_divider.sv | 29 ++
 rtl/telemetry_framer.sv | 164 ++++++++++++++++
 tb/tb_telemetry_framer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/telemetry_pkg.sv
// rtl/telemetry_pkg.sv - shared types and constants for the telemetry framer
package telemetry_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_SEQ,
        ST_MASK,
        ST_PAYLOAD,
        ST_CHK
    } tf_state_t;

    localparam int         TF_HDR_BYTES = 3;
    localparam int         TF_MAX_CH    = 8;
    localparam int         TF_CH_W      = $clog2(TF_MAX_CH);
    localparam logic [7:0] TF_SYNC      = 8'hA5;

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ cycles
module tick_divider #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 4
) (
    input  logic clk_50,
    input  logic reset,
    output logic tick
);

    localparam int PERIOD = CLK_HZ / TICK_HZ;
    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/telemetry_framer.sv
// rtl/telemetry_framer.sv - snapshots sensor channels and streams SYNC/SEQ/MASK/payload/CHK frames to the UART
module telemetry_framer
    import telemetry_pkg::*;
#(
    parameter int         NUM_CH    = 4,
    parameter int         CH_BYTES  = 2,
    parameter int         CLK_HZ    = 50_000_000,
    parameter int         TICK_HZ   = 4,
    parameter logic [7:0] SYNC_BYTE = TF_SYNC
) (
    input  logic                         clk_50,
    input  logic                         reset,
    input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic                         force_send,
    output logic [7:0]                   tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         busy,
    output logic [7:0]                   seq,
    output logic                         overrun
);

    tf_state_t r_state;
    tf_state_t w_next;

    logic [NUM_CH*CH_BYTES*8-1:0] r_data;
    logic [NUM_CH-1:0]            r_en;
    logic [TF_CH_W-1:0]           r_ch;
    logic [1:0]                   r_byte;
    logic [7:0]                   r_sum;
    logic [7:0]                   r_seq;
    logic                         r_overrun;

    logic                         w_tick;
    logic                         w_trig;
    logic                         w_accept;
    logic                         w_last_byte;
    logic [TF_CH_W-1:0]           w_first_ch;
    logic [TF_CH_W-1:0]           w_next_ch;
    logic                         w_has_next;
    logic [7:0]                   w_pay_byte;
    logic [7:0]                   w_mask;

    tick_divider #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_divider (
        .clk_50 (clk_50),
        .reset  (reset),
        .tick   (w_tick)
    );

    assign w_trig      = w_tick | force_send;
    assign w_accept    = tx_valid && tx_ready;
    assign w_last_byte = (r_byte == 2'(CH_BYTES - 1));
    assign w_mask      = 8'(r_en);

    // Descending scan leaves the lowest matching channel in each result.
    always_comb begin
        w_first_ch = '0;
        w_next_ch  = '0;
        w_has_next = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_en[i]) begin
                w_first_ch = TF_CH_W'(i);
                if (TF_CH_W'(i) > r_ch) begin
                    w_next_ch  = TF_CH_W'(i);
                    w_has_next = 1'b1;
                end
            end
        end
    end

    // Byte 0 of a channel is its most significant byte.
    always_comb begin
        w_pay_byte = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < CH_BYTES; b++) begin
                if (r_ch == TF_CH_W'(c) && r_byte == 2'(b)) begin
                    w_pay_byte = r_data[(c*CH_BYTES + CH_BYTES - 1 - b)*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_trig)   w_next = ST_SYNC;
            ST_SYNC:    if (w_accept) w_next = ST_SEQ;
            ST_SEQ:     if (w_accept) w_next = ST_MASK;
            ST_MASK:    if (w_accept) w_next = (|r_en) ? ST_PAYLOAD : ST_CHK;
            ST_PAYLOAD: if (w_accept && w_last_byte && !w_has_next) w_next = ST_CHK;
            ST_CHK:     if (w_accept) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid = (r_state != ST_IDLE);
        busy     = (r_state != ST_IDLE);
        seq      = r_seq;
        overrun  = r_overrun;
        case (r_state)
            ST_SYNC:    tx_data = SYNC_BYTE;
            ST_SEQ:     tx_data = r_seq;
            ST_MASK:    tx_data = w_mask;
            ST_PAYLOAD: tx_data = w_pay_byte;
            ST_CHK:     tx_data = 8'h00 - r_sum;
            default:    tx_data = 8'h00;
        endcase
    end

    // Shadow capture, payload walk, running sum and sequence counter.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_en      <= '0;
            r_ch      <= '0;
            r_byte    <= '0;
            r_sum     <= '0;
            r_seq     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_trig && (r_state != ST_IDLE);
            if (r_state == ST_IDLE && w_trig) begin
                r_data <= ch_data;
                r_en   <= ch_enable;
            end
            if (w_accept) begin
                case (r_state)
                    ST_SYNC: r_sum <= '0;
                    ST_SEQ:  r_sum <= r_sum + tx_data;
                    ST_MASK: begin
                        r_sum  <= r_sum + tx_data;
                        r_ch   <= w_first_ch;
                        r_byte <= '0;
                    end
                    ST_PAYLOAD: begin
                        r_sum <= r_sum + tx_data;
                        if (w_last_byte) begin
                            r_byte <= '0;
                            r_ch   <= w_next_ch;
                        end else begin
                            r_byte <= r_byte + 2'd1;
                        end
                    end
                    ST_CHK:  r_seq <= r_seq + 8'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_telemetry_framer.sv
// tb/tb_telemetry_framer.sv - directed self-checking bench for telemetry_framer (2 ch x 2 bytes, period 10)
module tb_telemetry_framer;

    localparam int NUM_CH   = 2;
    localparam int CH_BYTES = 2;
    localparam int CLK_HZ   = 100;
    localparam int TICK_HZ  = 10;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic [31:0] ch_data;
    logic [1:0]  ch_enable;
    logic        force_send;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [7:0]  seq;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] acc_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    logic [7:0] full_exp [8] = '{8'hA5, 8'h00, 8'h03, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'h3F};
    logic [7:0] bp_exp   [6] = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hB8};

    telemetry_framer #(
        .NUM_CH   (NUM_CH),
        .CH_BYTES (CH_BYTES),
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .ch_data   (ch_data),
        .ch_enable (ch_enable),
        .force_send(force_send),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .seq       (seq),
        .overrun   (overrun)
    );

    always #5 clk_50 = ~clk_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Records accepted bytes and verifies data/valid hold across stalls.
    always @(negedge clk_50) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_hold", 32'(tx_data), 32'(prev_data));
                check_eq("stall_valid", 32'(tx_valid), 32'd1);
            end
            if (tx_valid && tx_ready) acc_q.push_back(tx_data);
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
        end
    end

    task automatic step();
        @(posedge clk_50);
        cyc++;
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        force_send = 1'b0;
        step();
        step();
        reset = 1'b0;
        cyc   = 0;
        acc_q.delete();
    endtask

    initial begin
        reset      = 1'b1;
        ch_data    = 32'h1234_ABCD;
        ch_enable  = 2'b11;
        force_send = 1'b0;
        tx_ready   = 1'b1;

        do_reset();
        check_eq("rst_valid", 32'(tx_valid), 0);
        check_eq("rst_data", 32'(tx_data), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_seq", 32'(seq), 0);
        check_eq("rst_overrun", 32'(overrun), 0);

        force_send = 1'b1;
        step();
        force_send = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            check_eq($sformatf("full_b%0d", i), 32'(tx_data), 32'(full_exp[i]));
            check_eq($sformatf("full_v%0d", i), 32'(tx_valid), 1);
        end
        step();
        check_eq("full_end_busy", 32'(busy), 0);
        check_eq("full_end_valid", 32'(tx_valid), 0);
        check_eq("full_end_seq", 32'(seq), 1);

        ch_enable = 2'b00;
        do_reset();
        run_to(9);
        check_eq("per_idle9", 32'(tx_valid), 0);
        run_to(10);
        check_eq("per_start_v", 32'(tx_valid), 1);
        check_eq("per_start_d", 32'(tx_data), 32'hA5);
        run_to(60);
        check_eq("empty_sync", 32'(tx_data), 32'hA5);
        check_eq("empty_seqout", 32'(seq), 5);
        step();
        check_eq("empty_seq", 32'(tx_data), 32'h05);
        step();
        check_eq("empty_mask", 32'(tx_data), 32'h00);
        step();
        check_eq("empty_chk", 32'(tx_data), 32'hFB);
        step();
        check_eq("empty_done", 32'(tx_valid), 0);
        check_eq("empty_seq_next", 32'(seq), 6);

        ch_data   = 32'h1234_ABCD;
        ch_enable = 2'b10;
        tx_ready  = 1'b1;
        do_reset();
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        ch_data    = 32'hFFFF_FFFF;
        ch_enable  = 2'b11;
        tx_ready   = 1'b0;
        step();
        step();
        for (int k = 0; k < 200 && acc_q.size() < 6; k++) begin
            tx_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        check_eq("bp_count", 32'(acc_q.size() >= 6), 1);
        for (int i = 0; i < 6; i++) begin
            if (i < acc_q.size()) check_eq($sformatf("bp_b%0d", i), 32'(acc_q[i]), 32'(bp_exp[i]));
        end
        tx_ready = 1'b1;

        ch_data   = 32'h1234_ABCD;
        ch_enable = 2'b11;
        do_reset();
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        run_to(4);
        check_eq("ovr_pay", 32'(tx_data), 32'hAB);
        tx_ready = 1'b0;
        step();
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        check_eq("ovr_pulse", 32'(overrun), 1);
        check_eq("ovr_hold_d", 32'(tx_data), 32'hAB);
        check_eq("ovr_hold_v", 32'(tx_valid), 1);
        step();
        check_eq("ovr_clear", 32'(overrun), 0);
        tx_ready = 1'b1;
        run_to(12);
        check_eq("ovr_end_v", 32'(tx_valid), 0);
        check_eq("ovr_end_seq", 32'(seq), 1);
        step();
        check_eq("ovr_no_second", 32'(tx_valid), 0);
        check_eq("ovr_len", 32'(acc_q.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < acc_q.size()) check_eq($sformatf("ovr_b%0d", i), 32'(acc_q[i]), 32'(full_exp[i]));
        end

        ch_enable = 2'b00;
        do_reset();
        run_to(2560);
        check_eq("wrap_sync", 32'(tx_data), 32'hA5);
        check_eq("wrap_seq255", 32'(seq), 32'hFF);
        step();
        check_eq("wrap_seqbyte", 32'(tx_data), 32'hFF);
        run_to(2563);
        check_eq("wrap_chk", 32'(tx_data), 32'h01);
        run_to(2564);
        check_eq("wrap_seq0", 32'(seq), 0);
        run_to(2571);
        check_eq("wrap_next_seqbyte", 32'(tx_data), 32'h00);

        ch_enable = 2'b11;
        do_reset();
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        run_to(12);
        check_eq("rmid_mask", 32'(tx_data), 32'h03);
        check_eq("rmid_seq1", 32'(seq), 1);
        reset = 1'b1;
        #1;
        check_eq("rmid_valid", 32'(tx_valid), 0);
        check_eq("rmid_seq", 32'(seq), 0);
        check_eq("rmid_busy", 32'(busy), 0);
        do_reset();
        force_send = 1'b1;
        step();
        force_send = 1'b0;
        check_eq("rpost_sync", 32'(tx_data), 32'hA5);
        step();
        check_eq("rpost_seq", 32'(tx_data), 32'h00);
        run_to(8);
        check_eq("rpost_chk", 32'(tx_data), 32'h3F);
        run_to(9);
        check_eq("rpost_seq_next", 32'(seq), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
